clk_div_multi: RTL and testbench
================================

Name: clk_div_multi

Overview:
- Parametrised multi-channel clock divider, successor to the single-ratio divider.
- Each channel produces a divided clock from I_CLK with a runtime-programmable ratio and either 50%-duty or single-pulse output mode.
- New ratios are buffered and applied only at period boundaries, so outputs never glitch; channels can be phase-aligned with a common sync strobe.
- Sits between the board clock and slower logic: display scan, debounce, baud ticks.

Parameters:
CH, 4, number of independent channels
W, 16, width of per-channel divide ratio and counter
DEFAULT_DIV, 2, ratio loaded into every channel's active and pending registers at reset (must be >=2)

Ports:
I_CLK  input  1  system clock, rising edge active
rst  input  1  asynchronous reset, active-low (0 = reset)
en  input  CH  per-channel run enable
mode  input  CH  per-channel output mode: 0 = clock (near-50% duty), 1 = pulse (one-cycle high per period)
div_val  input  CH*W  per-channel requested ratio D; channel i uses bits [i*W +: W]
load  input  CH  per-channel strobe: capture div_val slice into pending register
sync  input  1  global strobe: restart all running channels at phase 0
O_CLK  output  CH  divided outputs, registered
tick  output  CH  one-cycle pulse marking the first I_CLK cycle of each period, registered
running  output  CH  channel currently generating periods

Behaviour:
- Reset (rst=0, async):
  - O_CLK, tick, running all 0.
  - Phase counters cleared to 0.
  - Active and pending ratios set to DEFAULT_DIV.
  - Release is synchronous to the next I_CLK edge.
- Effective ratio: Deff = (D<2) ? 2 : D. Ratios 0 and 1 are clamped and never stall the channel.
- Per-channel state machine, states IDLE, RUN, STOP:
  - IDLE: O_CLK=0, tick=0, running=0, phase=0. On an edge where en=1, go to RUN and start a period at phase 0.
  - RUN: phase counts 0..Deff-1 and wraps. At the edge that wraps, or when starting from IDLE, active ratio <= pending ratio. If en=0 is sampled, go to STOP.
  - STOP: the current period completes normally. At the edge where it would wrap, go to IDLE (O_CLK=0). If en=1 is sampled again before the wrap, return to RUN with no phase disturbance.
- Output timing:
  - O_CLK is registered. For the cycle at phase p, O_CLK = (p < H).
  - Clock mode: H = ceil(Deff/2). Example: D=5 gives 3 cycles high, 2 low.
  - Pulse mode: H = 1.
  - tick = 1 exactly when p = 0.
  - Latency: first O_CLK/tick high appears in the cycle after the edge that samples en=1.
- Ratio buffering:
  - load=1 captures div_val into pending at that edge.
  - When load coincides with a period boundary, the newly presented div_val is used for the next period, bypassing pending.
  - The active ratio never changes mid-period.
- mode changes are buffered and take effect at the same boundary as the ratio.
- sync=1: every channel in RUN or STOP restarts at phase 0 on that edge. Pending ratio and mode are applied (load-bypass rule included). tick=1 in the following cycle. IDLE channels ignore sync.
- Simultaneous en=0 and sync on a running channel: sync restarts the period and the channel stays in STOP, so it finishes that one new period and then idles.
- Reset mid-period: outputs drop to 0 immediately, with no completion of the current period.
- Counter width W. Max ratio is 2^W-1, with no overflow at wrap.

Test Plan:
1. Reset release, en[0]=1, D=default 2, clock mode → O_CLK[0] toggles every I_CLK cycle (1,0,1,0…); tick[0] high on each high cycle; running[0]=1 from the first post-enable cycle.
2. load ch1 D=5 while idle, then en[1]=1, clock mode → O_CLK[1] pattern 1,1,1,0,0 repeating; tick[1] every 5 cycles. Pulse mode with D=4 → 1,0,0,0 repeating.
3. Ch0 running D=6; assert load with D=3 at phase 2 → current period completes 6 cycles (1,1,1,0,0,0), then pattern 1,1,0 with no runt or stretched pulse.
4. Clear en[2] at phase 1 of a D=8 period → O_CLK[2] finishes 1,1,1,1,0,0,0 and then stays 0; running[2] falls after phase 7. Clearing en then re-asserting it before the wrap → uninterrupted output.
5. Channels at D=4 and D=6 with random phases; pulse sync → both show tick=1 in the same next cycle and both O_CLK rise together. An IDLE channel stays 0.
6. Drive rst=0 asynchronously mid-period (between clock edges) → all O_CLK/tick/running 0 immediately. After release, ratios are back to DEFAULT_DIV. D=0 or 1 loaded → behaves as D=2.

Source files
------------

// File: rtl/clk_div_multi_if.sv
// Control and output bundle for the multi-channel clock divider.
// The master drives enables, ratios and strobes; the divider drives the per-channel outputs.
interface clk_div_multi_if #(
  parameter int unsigned CH = 4,
  parameter int unsigned W  = 16
);
  logic [CH-1:0]   en;
  logic [CH-1:0]   mode;
  logic [CH*W-1:0] div_val;
  logic [CH-1:0]   load;
  logic            sync;
  logic [CH-1:0]   O_CLK;
  logic [CH-1:0]   tick;
  logic [CH-1:0]   running;

  modport master (
    output en, mode, div_val, load, sync,
    input  O_CLK, tick, running
  );

  modport slave (
    input  en, mode, div_val, load, sync,
    output O_CLK, tick, running
  );
endinterface

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider with boundary-buffered ratio/mode updates
// and a global phase-align strobe. Every output is registered.
module clk_div_multi #(
  parameter int unsigned CH          = 4,
  parameter int unsigned W           = 16,
  parameter int unsigned DEFAULT_DIV = 2
) (
  input  logic            I_CLK,
  input  logic            rst,
  clk_div_multi_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_e;

  // Ratios 0 and 1 behave as 2 so a channel can never stall.
  function automatic logic [W-1:0] eff_div(input logic [W-1:0] d);
    return (d < W'(2)) ? W'(2) : d;
  endfunction

  // Number of high cycles per period; one bit wider so ceil(d/2) cannot overflow.
  function automatic logic [W:0] high_len(input logic [W-1:0] d, input logic pulse);
    if (pulse) return (W+1)'(1);
    return ({1'b0, d} + (W+1)'(1)) >> 1;
  endfunction

  for (genvar i = 0; i < CH; i++) begin : g_ch
    state_e         state_q, state_d;
    logic [W-1:0]   phase_q, phase_d;
    logic [W-1:0]   act_q, act_d;
    logic [W-1:0]   pend_q, pend_d;
    logic           mode_q, mode_d;
    logic           o_clk_q, o_clk_d;
    logic           tick_q, tick_d;
    logic           run_q, run_d;
    logic [W-1:0]   req_div_c;
    logic [W-1:0]   new_div_c;
    logic [W-1:0]   eff_c;
    logic           wrap_c;
    logic           restart_c;

    // A load on a boundary edge feeds the new period directly instead of via pending.
    assign req_div_c = bus.div_val[i*W +: W];
    assign new_div_c = bus.load[i] ? req_div_c : pend_q;
    assign eff_c     = eff_div(act_q);
    assign wrap_c    = (phase_q == (eff_c - W'(1)));

    always_ff @(posedge I_CLK or negedge rst) begin
      if (!rst) begin
        state_q <= IDLE;
        phase_q <= '0;
        act_q   <= W'(DEFAULT_DIV);
        pend_q  <= W'(DEFAULT_DIV);
        mode_q  <= 1'b0;
        o_clk_q <= 1'b0;
        tick_q  <= 1'b0;
        run_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        phase_q <= phase_d;
        act_q   <= act_d;
        pend_q  <= pend_d;
        mode_q  <= mode_d;
        o_clk_q <= o_clk_d;
        tick_q  <= tick_d;
        run_q   <= run_d;
      end
    end

    always_comb begin
      state_d   = state_q;
      phase_d   = phase_q;
      act_d     = act_q;
      pend_d    = bus.load[i] ? req_div_c : pend_q;
      mode_d    = mode_q;
      o_clk_d   = 1'b0;
      tick_d    = 1'b0;
      run_d     = 1'b0;
      restart_c = 1'b0;

      unique case (state_q)
        IDLE: begin
          phase_d = '0;
          if (bus.en[i]) begin
            state_d   = RUN;
            restart_c = 1'b1;
          end
        end
        RUN, STOP: begin
          if (bus.sync) begin
            state_d   = bus.en[i] ? RUN : STOP;
            restart_c = 1'b1;
          end else if (wrap_c) begin
            if (bus.en[i]) begin
              state_d   = RUN;
              restart_c = 1'b1;
            end else begin
              state_d = IDLE;
              phase_d = '0;
            end
          end else begin
            state_d = bus.en[i] ? RUN : STOP;
            phase_d = phase_q + W'(1);
            run_d   = 1'b1;
            o_clk_d = ({1'b0, phase_d} < high_len(eff_c, mode_q));
          end
        end
        default: begin
          state_d = IDLE;
          phase_d = '0;
        end
      endcase

      // Period boundary: latch the next ratio and mode, emit phase 0.
      if (restart_c) begin
        phase_d = '0;
        act_d   = new_div_c;
        mode_d  = bus.mode[i];
        o_clk_d = 1'b1;
        tick_d  = 1'b1;
        run_d   = 1'b1;
      end
    end

    assign bus.O_CLK[i]   = o_clk_q;
    assign bus.tick[i]    = tick_q;
    assign bus.running[i] = run_q;
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed, table-driven bench for clk_div_multi: 4 channels, 16-bit ratios.
// Inputs change on the falling edge; outputs are sampled on the following falling edge.
module tb_clk_div_multi;

  logic clk = 1'b0;
  logic rst;
  int   total;
  int   bad;

  clk_div_multi_if #(.CH(4), .W(16)) bus ();

  clk_div_multi #(.CH(4), .W(16), .DEFAULT_DIV(2)) dut (
    .I_CLK (clk),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  en;
    logic [3:0]  mode;
    logic [3:0]  load;
    logic [15:0] d1;
    logic [3:0]  exp_clk;
    logic [3:0]  exp_tick;
    logic [3:0]  exp_run;
  } vec_t;

  vec_t tbl [16];

  bit s3_clk  [12] = '{1,1,1,0,0,0,1,1,0,1,1,0};
  bit s3_tick [12] = '{1,0,0,0,0,0,1,0,0,1,0,0};

  bit s4_en   [20] = '{1,1,0,0,0,0,0,0,0,0,1,1,0,1,1,1,1,1,1,1};
  bit s4_clk  [20] = '{1,1,1,1,0,0,0,0,0,0,1,1,1,1,0,0,0,0,1,1};
  bit s4_run  [20] = '{1,1,1,1,1,1,1,1,0,0,1,1,1,1,1,1,1,1,1,1};

  logic [3:0] s5_en   [14] = '{4'b0001,4'b0001,4'b0001,4'b0011,4'b0011,4'b0011,4'b0011,
                                4'b0011,4'b0011,4'b0010,4'b0010,4'b0010,4'b0010,4'b0010};
  bit         s5_sync [14] = '{0,0,0,0,0,0,1,0,0,1,0,0,0,0};
  logic [3:0] s5_clk  [14] = '{4'b0001,4'b0001,4'b0000,4'b0010,4'b0011,4'b0011,4'b0011,
                                4'b0011,4'b0010,4'b0011,4'b0011,4'b0010,4'b0000,4'b0000};
  logic [3:0] s5_tick [14] = '{4'b0001,4'b0000,4'b0000,4'b0010,4'b0001,4'b0000,4'b0011,
                                4'b0000,4'b0000,4'b0011,4'b0000,4'b0000,4'b0000,4'b0000};
  logic [3:0] s5_run  [14] = '{4'b0001,4'b0001,4'b0001,4'b0011,4'b0011,4'b0011,4'b0011,
                                4'b0011,4'b0011,4'b0011,4'b0011,4'b0011,4'b0011,4'b0010};

  task automatic chk(input string nm, input int k, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%b want=%b", nm, k, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.en      = '0;
    bus.mode    = '0;
    bus.load    = '0;
    bus.sync    = 1'b0;
    bus.div_val = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;

    // en, mode, load, d1, exp O_CLK, exp tick, exp running
    tbl[0]  = '{4'b0000, 4'b0000, 4'b0010, 16'd5, 4'b0000, 4'b0000, 4'b0000};
    tbl[1]  = '{4'b0011, 4'b0000, 4'b0000, 16'd0, 4'b0011, 4'b0011, 4'b0011};
    tbl[2]  = '{4'b0011, 4'b0000, 4'b0000, 16'd0, 4'b0010, 4'b0000, 4'b0011};
    tbl[3]  = '{4'b0011, 4'b0000, 4'b0000, 16'd0, 4'b0011, 4'b0001, 4'b0011};
    tbl[4]  = '{4'b0011, 4'b0000, 4'b0000, 16'd0, 4'b0000, 4'b0000, 4'b0011};
    tbl[5]  = '{4'b0011, 4'b0000, 4'b0000, 16'd0, 4'b0001, 4'b0001, 4'b0011};
    tbl[6]  = '{4'b0011, 4'b0000, 4'b0000, 16'd0, 4'b0010, 4'b0010, 4'b0011};
    tbl[7]  = '{4'b0011, 4'b0000, 4'b0000, 16'd0, 4'b0011, 4'b0001, 4'b0011};
    tbl[8]  = '{4'b0011, 4'b0010, 4'b0010, 16'd4, 4'b0010, 4'b0000, 4'b0011};
    tbl[9]  = '{4'b0011, 4'b0010, 4'b0000, 16'd0, 4'b0001, 4'b0001, 4'b0011};
    tbl[10] = '{4'b0011, 4'b0010, 4'b0000, 16'd0, 4'b0000, 4'b0000, 4'b0011};
    tbl[11] = '{4'b0011, 4'b0010, 4'b0000, 16'd0, 4'b0011, 4'b0011, 4'b0011};
    tbl[12] = '{4'b0011, 4'b0010, 4'b0000, 16'd0, 4'b0000, 4'b0000, 4'b0011};
    tbl[13] = '{4'b0011, 4'b0010, 4'b0000, 16'd0, 4'b0001, 4'b0001, 4'b0011};
    tbl[14] = '{4'b0011, 4'b0010, 4'b0000, 16'd0, 4'b0000, 4'b0000, 4'b0011};
    tbl[15] = '{4'b0011, 4'b0010, 4'b0000, 16'd0, 4'b0011, 4'b0011, 4'b0011};

    do_reset();
    chk("reset_clk",  0, bus.O_CLK,   4'b0000);
    chk("reset_tick", 0, bus.tick,    4'b0000);
    chk("reset_run",  0, bus.running, 4'b0000);

    // Default ratio on ch0, D=5 clock then D=4 pulse on ch1.
    for (int k = 0; k < 16; k++) begin
      bus.en               = tbl[k].en;
      bus.mode             = tbl[k].mode;
      bus.load             = tbl[k].load;
      bus.div_val[16 +: 16] = tbl[k].d1;
      step();
      chk("tbl_clk",  k, bus.O_CLK,   tbl[k].exp_clk);
      chk("tbl_tick", k, bus.tick,    tbl[k].exp_tick);
      chk("tbl_run",  k, bus.running, tbl[k].exp_run);
    end

    // Ratio change 6 -> 3 presented mid-period waits for the boundary.
    do_reset();
    for (int k = 0; k < 12; k++) begin
      bus.en               = 4'b0001;
      bus.load             = (k == 0 || k == 3) ? 4'b0001 : 4'b0000;
      bus.div_val[0 +: 16] = (k == 0) ? 16'd6 : 16'd3;
      step();
      chk("s3_clk",  k, {3'b000, bus.O_CLK[0]},   {3'b000, s3_clk[k]});
      chk("s3_tick", k, {3'b000, bus.tick[0]},    {3'b000, s3_tick[k]});
      chk("s3_run",  k, {3'b000, bus.running[0]}, 4'b0001);
    end

    // Stop completes the period; re-enable before the wrap is seamless.
    do_reset();
    for (int k = 0; k < 20; k++) begin
      bus.en                = {1'b0, s4_en[k], 2'b00};
      bus.load              = (k == 0) ? 4'b0100 : 4'b0000;
      bus.div_val[32 +: 16] = 16'd8;
      step();
      chk("s4_clk", k, {3'b000, bus.O_CLK[2]},   {3'b000, s4_clk[k]});
      chk("s4_run", k, {3'b000, bus.running[2]}, {3'b000, s4_run[k]});
    end

    // Sync aligns D=4 and D=6 channels; sync with en low gives one last period.
    do_reset();
    for (int k = 0; k < 14; k++) begin
      bus.en                = s5_en[k];
      bus.sync              = s5_sync[k];
      bus.load              = (k == 0) ? 4'b0011 : 4'b0000;
      bus.div_val[0 +: 16]  = 16'd4;
      bus.div_val[16 +: 16] = 16'd6;
      step();
      chk("s5_clk",  k, bus.O_CLK,   s5_clk[k]);
      chk("s5_tick", k, bus.tick,    s5_tick[k]);
      chk("s5_run",  k, bus.running, s5_run[k]);
    end
    bus.sync = 1'b0;

    // Asynchronous reset mid-period, then defaults and clamped ratios.
    do_reset();
    bus.en                = 4'b0011;
    bus.load              = 4'b0010;
    bus.div_val[16 +: 16] = 16'd5;
    step();
    chk("s6_pre_clk", 0, bus.O_CLK, 4'b0011);
    bus.load = 4'b0000;
    step();
    chk("s6_pre_clk", 1, bus.O_CLK, 4'b0010);
    #2 rst = 1'b0;
    #1;
    chk("s6_async_clk",  0, bus.O_CLK,   4'b0000);
    chk("s6_async_tick", 0, bus.tick,    4'b0000);
    chk("s6_async_run",  0, bus.running, 4'b0000);
    clear_inputs();
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.en                = 4'b1110;
      bus.load              = (k == 0) ? 4'b1100 : 4'b0000;
      bus.div_val[32 +: 16] = 16'd0;
      bus.div_val[48 +: 16] = 16'd1;
      step();
      chk("s6_clk",  k, bus.O_CLK,   (k % 2 == 0) ? 4'b1110 : 4'b0000);
      chk("s6_tick", k, bus.tick,    (k % 2 == 0) ? 4'b1110 : 4'b0000);
      chk("s6_run",  k, bus.running, 4'b1110);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
